// File: rtl/bcd_display_scanner.sv
// Four-digit common-anode scanner fed by the binary-to-BCD converter.
// It provides a load-captured shadow, leading-zero blanking, a dash for non-decimal nibbles, and a frame pulse.
module bcd_display_scanner #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [27:0] bcd_in,
  input  logic        blank_en,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic          wrap_pend;
  logic          tick;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    glyph;
  logic          z_th, z_hu, z_te;
  logic          unused_bits;

  assign unused_bits = ^bcd_in[11:0];
  assign tick = (presc == PW'(REFRESH_DIV - 1));
  assign z_th = (shadow[15:12] == 4'h0);
  assign z_hu = (shadow[11:8]  == 4'h0);
  assign z_te = (shadow[7:4]   == 4'h0);

  // Only an exact 0 nibble blanks, so invalid nibbles keep lower digits lit.
  always_comb begin
    nib   = shadow[3:0];
    blank = 1'b0;
    case (idx)
      2'd0: begin nib = shadow[3:0];   blank = 1'b0; end
      2'd1: begin nib = shadow[7:4];   blank = blank_en && z_th && z_hu && z_te; end
      2'd2: begin nib = shadow[11:8];  blank = blank_en && z_th && z_hu; end
      default: begin nib = shadow[15:12]; blank = blank_en && z_th; end
    endcase
  end

  always_comb begin
    glyph = 7'h3F;
    case (nib)
      4'd0: glyph = 7'h40;
      4'd1: glyph = 7'h79;
      4'd2: glyph = 7'h24;
      4'd3: glyph = 7'h30;
      4'd4: glyph = 7'h19;
      4'd5: glyph = 7'h12;
      4'd6: glyph = 7'h02;
      4'd7: glyph = 7'h78;
      4'd8: glyph = 7'h00;
      4'd9: glyph = 7'h10;
      default: glyph = 7'h3F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      idx        <= 2'd0;
      shadow     <= 16'h0000;
      wrap_pend  <= 1'b0;
      frame_tick <= 1'b0;
      seg        <= 7'h7F;
      an         <= 4'b1111;
    end else begin
      if (tick) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + PW'(1);
      end
      if (load) shadow <= bcd_in[27:12];
      // The 3->0 advance is remembered so the pulse lines up with the first registered units output.
      wrap_pend  <= tick && (idx == 2'd3);
      frame_tick <= wrap_pend;
      seg        <= blank ? 7'h7F : glyph;
      an         <= blank ? 4'b1111 : ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with REFRESH_DIV=4.
// Each edge's expected outputs come from a small scan model and pass through a scoreboard queue.
module tb_bcd_display_scanner;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst, load, blank_en;
  logic [27:0] bcd_in;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       ft;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          k = 0;
  logic [15:0] m_sh = 16'h0000;

  bcd_display_scanner #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .blank_en(blank_en),
    .seg(seg), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // One clock: drive inputs on the falling edge, predict, then compare just after the rising edge.
  task automatic step(input string tag, input logic ld, input logic [27:0] val,
                      input logic bl, input logic r);
    exp_t       e;
    int         slot;
    logic       blk;
    logic [3:0] n;
    logic       z3, z2, z1;
    @(negedge clk);
    load = ld; bcd_in = val; blank_en = bl; rst = r;
    if (r) begin
      e.an = 4'b1111; e.seg = 7'h7F; e.ft = 1'b0;
    end else begin
      slot = (k / DIV) % 4;
      n  = m_sh[slot*4 +: 4];
      z3 = (m_sh[15:12] == 4'h0);
      z2 = (m_sh[11:8]  == 4'h0);
      z1 = (m_sh[7:4]   == 4'h0);
      case (slot)
        0: blk = 1'b0;
        1: blk = bl && z3 && z2 && z1;
        2: blk = bl && z3 && z2;
        default: blk = bl && z3;
      endcase
      case (slot)
        0: e.an = 4'b1110;
        1: e.an = 4'b1101;
        2: e.an = 4'b1011;
        default: e.an = 4'b0111;
      endcase
      if (blk) begin
        e.an = 4'b1111; e.seg = 7'h7F;
      end else begin
        e.seg = glyph(n);
      end
      e.ft = (k > 0) && (k % (4 * DIV) == 0);
    end
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    checks++;
    assert (an === e.an) else begin
      errors++; $error("FAIL %s k=%0d an got=%b exp=%b", tag, k, an, e.an);
    end
    checks++;
    assert (seg === e.seg) else begin
      errors++; $error("FAIL %s k=%0d seg got=%h exp=%h", tag, k, seg, e.seg);
    end
    checks++;
    assert (frame_tick === e.ft) else begin
      errors++; $error("FAIL %s k=%0d frame_tick got=%b exp=%b", tag, k, frame_tick, e.ft);
    end
    if (r) begin
      m_sh = 16'h0000; k = 0;
    end else begin
      if (ld) m_sh = val[27:12];
      k++;
    end
  endtask

  task automatic run(input string tag, input int cycles, input logic bl);
    for (int i = 0; i < cycles; i++) step(tag, 1'b0, 28'h0, bl, 1'b0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; bcd_in = 28'h0; blank_en = 1'b0;
    for (int i = 0; i < 3; i++) step("reset", 1'b0, 28'h0, 1'b0, 1'b1);
    run("por_zero", 16, 1'b0);

    step("load_1234", 1'b1, 28'h1234000, 1'b0, 1'b0);
    run("scan_1234", 32, 1'b0);

    step("load_0042", 1'b1, 28'h0042FFF, 1'b1, 1'b0);
    run("blank_0042", 16, 1'b1);
    run("noblank_0042", 16, 1'b0);

    step("load_0305", 1'b1, 28'h0305000, 1'b1, 1'b0);
    run("zeros_0305", 16, 1'b1);
    step("load_0000", 1'b1, 28'h0000000, 1'b1, 1'b0);
    run("zero_blank", 16, 1'b1);

    step("load_00A7", 1'b1, 28'h00A7000, 1'b1, 1'b0);
    run("invalid_00A7", 16, 1'b1);

    while (k % 16 != 7) step("align_tick", 1'b0, 28'h0, 1'b0, 1'b0);
    step("load_on_tick", 1'b1, 28'h9999000, 1'b0, 1'b0);
    step("after_tick", 1'b0, 28'h0, 1'b0, 1'b0);
    while (k % 16 != 13) step("align_rst", 1'b0, 28'h0, 1'b0, 1'b0);
    step("rst_mid", 1'b1, 28'h1234000, 1'b0, 1'b1);
    run("post_rst", 20, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
